// File: rtl/regfile_sequencer.sv
// Sequences the register file's edge-triggered x/y read and z write ports around an ALU
// start/done handshake, sharing the z write port with a loader via round-robin arbitration.
module regfile_sequencer #(
  parameter int unsigned W           = 8,
  parameter int unsigned SEL_W       = 4,
  parameter int unsigned ALU_TIMEOUT = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [SEL_W-1:0] op_x_sel,
  input  logic [SEL_W-1:0] op_y_sel,
  input  logic [SEL_W-1:0] op_z_sel,
  input  logic             op_wb,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [SEL_W-1:0] ld_sel,
  input  logic [W-1:0]     ld_data,
  output logic             rf_x_enb,
  output logic             rf_y_enb,
  output logic             rf_z_enb,
  output logic [SEL_W-1:0] rf_x_sel,
  output logic [SEL_W-1:0] rf_y_sel,
  output logic [SEL_W-1:0] rf_z_sel,
  output logic [W-1:0]     rf_z_in,
  output logic             alu_start,
  input  logic             alu_done,
  input  logic [W-1:0]     alu_result,
  output logic             done,
  output logic             error,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(ALU_TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StRead, StSettle, StExec, StWrite, StRelease} state_e;
  typedef enum logic {SrcOp, SrcLd} src_e;

  state_e             state_q;
  src_e               src_q;
  src_e               last_grant_q;
  logic               wb_q;
  logic [SEL_W-1:0]   dst_q;
  logic [CntW-1:0]    cnt_q;

  logic               x_enb_q, y_enb_q, z_enb_q;
  logic [SEL_W-1:0]   x_sel_q, y_sel_q, z_sel_q;
  logic [W-1:0]       z_in_q;
  logic               alu_start_q, done_q, error_q, busy_q;

  logic idle;
  logic op_grant, ld_grant;

  // On a tie the requester that was not granted last wins.
  always_comb begin
    idle     = !reset && (state_q == StIdle);
    op_grant = op_valid && (!ld_valid || (last_grant_q == SrcLd));
    ld_grant = ld_valid && (!op_valid || (last_grant_q == SrcOp));
    op_ready = idle && op_grant;
    ld_ready = idle && ld_grant;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      src_q        <= SrcOp;
      last_grant_q <= SrcLd;
      wb_q         <= 1'b0;
      dst_q        <= '0;
      cnt_q        <= '0;
      x_enb_q      <= 1'b0;
      y_enb_q      <= 1'b0;
      z_enb_q      <= 1'b0;
      x_sel_q      <= '0;
      y_sel_q      <= '0;
      z_sel_q      <= '0;
      z_in_q       <= '0;
      alu_start_q  <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      // Pulse outputs default low so every enable lasts exactly one cycle.
      x_enb_q     <= 1'b0;
      y_enb_q     <= 1'b0;
      z_enb_q     <= 1'b0;
      alu_start_q <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      case (state_q)
        StIdle: begin
          if (op_ready) begin
            state_q      <= StRead;
            busy_q       <= 1'b1;
            src_q        <= SrcOp;
            last_grant_q <= SrcOp;
            wb_q         <= op_wb;
            dst_q        <= op_z_sel;
            x_sel_q      <= op_x_sel;
            y_sel_q      <= op_y_sel;
            x_enb_q      <= 1'b1;
            y_enb_q      <= 1'b1;
          end else if (ld_ready) begin
            state_q      <= StWrite;
            busy_q       <= 1'b1;
            src_q        <= SrcLd;
            last_grant_q <= SrcLd;
            z_sel_q      <= ld_sel;
            z_in_q       <= ld_data;
            z_enb_q      <= 1'b1;
          end
        end
        StRead: begin
          state_q     <= StSettle;
          alu_start_q <= 1'b1;
        end
        StSettle: begin
          state_q <= StExec;
          cnt_q   <= '0;
        end
        StExec: begin
          if (alu_done) begin
            cnt_q <= '0;
            if (wb_q) begin
              state_q <= StWrite;
              z_sel_q <= dst_q;
              z_in_q  <= alu_result;
              z_enb_q <= 1'b1;
            end else begin
              state_q <= StRelease;
              done_q  <= 1'b1;
            end
          end else if (cnt_q == CntW'(ALU_TIMEOUT - 1)) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            error_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StWrite: begin
          state_q <= StRelease;
          done_q  <= (src_q == SrcOp);
        end
        StRelease: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rf_x_enb  = x_enb_q;
  assign rf_y_enb  = y_enb_q;
  assign rf_z_enb  = z_enb_q;
  assign rf_x_sel  = x_sel_q;
  assign rf_y_sel  = y_sel_q;
  assign rf_z_sel  = z_sel_q;
  assign rf_z_in   = z_in_q;
  assign alu_start = alu_start_q;
  assign done      = done_q;
  assign error     = error_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Self-checking bench for regfile_sequencer: directed transaction table plus randomized
// transactions, each expanded into a per-cycle expected output timeline.
module tb_regfile_sequencer;

  localparam int unsigned W     = 8;
  localparam int unsigned SEL_W = 4;
  localparam int unsigned TO    = 15;

  logic             clock = 1'b0;
  logic             reset;
  logic             op_valid, op_ready, op_wb;
  logic [SEL_W-1:0] op_x_sel, op_y_sel, op_z_sel;
  logic             ld_valid, ld_ready;
  logic [SEL_W-1:0] ld_sel;
  logic [W-1:0]     ld_data;
  logic             rf_x_enb, rf_y_enb, rf_z_enb;
  logic [SEL_W-1:0] rf_x_sel, rf_y_sel, rf_z_sel;
  logic [W-1:0]     rf_z_in;
  logic             alu_start, alu_done;
  logic [W-1:0]     alu_result;
  logic             done, error, busy;

  always #5 clock = ~clock;

  regfile_sequencer #(
    .W          (W),
    .SEL_W      (SEL_W),
    .ALU_TIMEOUT(TO)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_x_sel  (op_x_sel),
    .op_y_sel  (op_y_sel),
    .op_z_sel  (op_z_sel),
    .op_wb     (op_wb),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_sel    (ld_sel),
    .ld_data   (ld_data),
    .rf_x_enb  (rf_x_enb),
    .rf_y_enb  (rf_y_enb),
    .rf_z_enb  (rf_z_enb),
    .rf_x_sel  (rf_x_sel),
    .rf_y_sel  (rf_y_sel),
    .rf_z_sel  (rf_z_sel),
    .rf_z_in   (rf_z_in),
    .alu_start (alu_start),
    .alu_done  (alu_done),
    .alu_result(alu_result),
    .done      (done),
    .error     (error),
    .busy      (busy)
  );

  typedef struct packed {
    logic       xe, ye, ze, st, dn, er, bz, opr, ldr;
    logic [3:0] xs, ys, zs;
    logic [7:0] zin;
  } obs_t;

  // k = EXEC cycle (0-based) in which alu_done is raised; k >= TO means never.
  typedef struct {
    bit         ov, lv, hold;
    logic [3:0] x, y, z;
    bit         wb;
    int         k;
    logic [7:0] res;
    logic [3:0] ls;
    logic [7:0] ld;
    bit         exp_known, exp_op;
    int         exp_lat, abort_at;
  } txn_t;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state: values the register-file-facing outputs should be holding.
  logic [3:0] m_xs, m_ys, m_zs;
  logic [7:0] m_zin;
  bit         m_last_ld, m_err_pending;

  function automatic void model_reset();
    m_xs = '0; m_ys = '0; m_zs = '0; m_zin = '0;
    m_last_ld = 1'b1; m_err_pending = 1'b0;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.xe = rf_x_enb; o.ye = rf_y_enb; o.ze = rf_z_enb; o.st = alu_start;
    o.dn = done; o.er = error; o.bz = busy; o.opr = op_ready; o.ldr = ld_ready;
    o.xs = rf_x_sel; o.ys = rf_y_sel; o.zs = rf_z_sel; o.zin = rf_z_in;
    return o;
  endfunction

  function automatic obs_t quiet(bit bz);
    obs_t o;
    o = '0;
    o.bz = bz; o.xs = m_xs; o.ys = m_ys; o.zs = m_zs; o.zin = m_zin;
    return o;
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("xe%b ye%b ze%b st%b dn%b er%b bz%b opr%b ldr%b xs%h ys%h zs%h zin%h",
                     o.xe, o.ye, o.ze, o.st, o.dn, o.er, o.bz, o.opr, o.ldr,
                     o.xs, o.ys, o.zs, o.zin);
  endfunction

  task automatic check(input obs_t exp, input string name, input int cyc);
    obs_t act;
    act = sample();
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s T+%0d: got {%s} want {%s}", name, cyc, fmt(act), fmt(exp));
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic txn_t mk(bit ov, bit lv, bit hold, logic [3:0] x, logic [3:0] y,
                              logic [3:0] z, bit wb, int k, logic [7:0] res, logic [3:0] ls,
                              logic [7:0] ld, bit exp_op, int exp_lat, int abort_at);
    txn_t t;
    t.ov = ov; t.lv = lv; t.hold = hold; t.x = x; t.y = y; t.z = z; t.wb = wb; t.k = k;
    t.res = res; t.ls = ls; t.ld = ld; t.exp_known = 1'b1; t.exp_op = exp_op;
    t.exp_lat = exp_lat; t.abort_at = abort_at;
    return t;
  endfunction

  // Starts in an IDLE cycle just after a clock edge; ends in the next IDLE cycle.
  task automatic run_txn(input txn_t t, input string name);
    obs_t q[$];
    obs_t e;
    bit   win_op;
    int   n_exec, done_rel, busy_cnt, r;

    op_valid = t.ov; ld_valid = t.lv;
    op_x_sel = t.x; op_y_sel = t.y; op_z_sel = t.z; op_wb = t.wb;
    ld_sel = t.ls; ld_data = t.ld;
    alu_done = 1'($urandom_range(0, 1)); alu_result = 8'($urandom);
    #1;
    e = quiet(1'b0);
    e.er  = m_err_pending;
    e.opr = t.ov && (!t.lv || m_last_ld);
    e.ldr = t.lv && (!t.ov || !m_last_ld);
    check(e, name, 0);
    if (t.exp_known) begin
      n_vec++;
      if (op_ready !== t.exp_op || ld_ready !== !t.exp_op) begin
        n_bad++;
        $display("FAIL %s grant: got op_ready=%b ld_ready=%b want op_ready=%b", name,
                 op_ready, ld_ready, t.exp_op);
      end
    end

    win_op = e.opr;
    m_last_ld = !win_op;
    m_err_pending = 1'b0;
    n_exec = 0;
    done_rel = -1;
    if (win_op) begin
      m_xs = t.x; m_ys = t.y;
      e = quiet(1'b1); e.xe = 1'b1; e.ye = 1'b1; q.push_back(e);
      e = quiet(1'b1); e.st = 1'b1; q.push_back(e);
      n_exec = (t.k < int'(TO)) ? t.k + 1 : int'(TO);
      repeat (n_exec) q.push_back(quiet(1'b1));
      if (t.k < int'(TO)) begin
        done_rel = 3 + t.k;
        if (t.wb) begin
          m_zs = t.z; m_zin = t.res;
          e = quiet(1'b1); e.ze = 1'b1; q.push_back(e);
        end
        e = quiet(1'b1); e.dn = 1'b1; q.push_back(e);
      end else begin
        m_err_pending = 1'b1;
      end
    end else begin
      m_zs = t.ls; m_zin = t.ld;
      e = quiet(1'b1); e.ze = 1'b1; q.push_back(e);
      q.push_back(quiet(1'b1));
    end

    busy_cnt = 0;
    for (int i = 0; i < q.size(); i++) begin
      r = i + 1;
      tick();
      if (!t.hold) begin
        op_valid = 1'($urandom_range(0, 1));
        ld_valid = 1'($urandom_range(0, 1));
      end
      op_x_sel = 4'($urandom); op_y_sel = 4'($urandom); op_z_sel = 4'($urandom);
      op_wb = 1'($urandom_range(0, 1)); ld_sel = 4'($urandom); ld_data = 8'($urandom);
      if (r == done_rel) begin
        alu_done = 1'b1; alu_result = t.res;
      end else if (win_op && r >= 3 && r < 3 + n_exec) begin
        alu_done = 1'b0; alu_result = 8'($urandom);
      end else begin
        alu_done = 1'($urandom_range(0, 1)); alu_result = 8'($urandom);
      end
      if (r == t.abort_at) reset = 1'b1;
      #1;
      check(q[i], name, r);
      if (busy) busy_cnt++;
      if (r == t.abort_at) begin
        tick();
        reset = 1'b0;
        model_reset();
        return;
      end
    end
    tick();
    if (t.exp_lat > 0) begin
      n_vec++;
      if (busy_cnt + 1 != t.exp_lat || busy !== 1'b0) begin
        n_bad++;
        $display("FAIL %s latency: got %0d busy cycles (busy now %b) want idle at T+%0d",
                 name, busy_cnt, busy, t.exp_lat);
      end
    end
  endtask

  txn_t tab[13];

  initial begin
    txn_t t;
    obs_t e;
    int   sel;

    tab[0]  = mk(1, 0, 0, 4'h5, 4'h6, 4'h7, 1, 0,  8'h3C, 4'h0, 8'h00, 1, 6,  0);
    tab[1]  = mk(1, 0, 0, 4'h1, 4'h2, 4'h3, 0, 3,  8'h55, 4'h0, 8'h00, 1, 8,  0);
    tab[2]  = mk(0, 1, 0, 4'h0, 4'h0, 4'h0, 0, 0,  8'h00, 4'hA, 8'h81, 0, 3,  0);
    tab[3]  = mk(1, 0, 0, 4'h2, 4'h4, 4'h9, 1, 99, 8'h11, 4'h0, 8'h00, 1, 18, 0);
    tab[4]  = mk(1, 0, 0, 4'h3, 4'h3, 4'h0, 1, 1,  8'hA5, 4'h0, 8'h00, 1, 7,  0);
    tab[5]  = mk(1, 0, 0, 4'h4, 4'h5, 4'h6, 1, 99, 8'h00, 4'h0, 8'h00, 1, 0,  5);
    tab[6]  = mk(1, 1, 1, 4'h5, 4'h6, 4'h7, 1, 0,  8'h3C, 4'hB, 8'h22, 1, 6,  0);
    tab[7]  = mk(1, 1, 1, 4'h1, 4'h1, 4'h1, 1, 0,  8'h00, 4'hC, 8'h33, 0, 3,  0);
    tab[8]  = mk(1, 1, 1, 4'h1, 4'h2, 4'h8, 0, 2,  8'h44, 4'h2, 8'h55, 1, 7,  0);
    tab[9]  = mk(1, 1, 1, 4'h2, 4'h2, 4'h2, 1, 0,  8'h00, 4'hD, 8'h66, 0, 3,  0);
    tab[10] = mk(1, 0, 0, 4'h7, 4'h8, 4'h9, 1, 0,  8'h99, 4'h0, 8'h00, 1, 0,  4);
    tab[11] = mk(1, 0, 0, 4'h1, 4'h1, 4'h1, 1, 0,  8'h77, 4'h0, 8'h00, 1, 6,  0);
    tab[12] = mk(0, 1, 0, 4'h0, 4'h0, 4'h0, 0, 0,  8'h00, 4'hF, 8'hFF, 0, 3,  0);

    reset = 1'b1;
    op_valid = 1'b0; ld_valid = 1'b0; op_wb = 1'b0;
    op_x_sel = '0; op_y_sel = '0; op_z_sel = '0; ld_sel = '0; ld_data = '0;
    alu_done = 1'b0; alu_result = '0;
    model_reset();
    tick();
    tick();
    // Readies must stay low while reset is held, even with both requests pending.
    op_valid = 1'b1; ld_valid = 1'b1;
    #1;
    e = quiet(1'b0);
    check(e, "reset", 0);
    tick();
    reset = 1'b0;

    for (int i = 0; i < 13; i++) run_txn(tab[i], $sformatf("dir%0d", i));

    for (int n = 0; n < 60; n++) begin
      sel = int'($urandom_range(0, 2));
      t.ov = (sel != 1); t.lv = (sel != 0); t.hold = 1'($urandom_range(0, 1));
      t.x = 4'($urandom); t.y = 4'($urandom); t.z = 4'($urandom);
      t.wb = 1'($urandom_range(0, 1));
      t.k = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 5));
      t.res = 8'($urandom); t.ls = 4'($urandom); t.ld = 8'($urandom);
      t.exp_known = 1'b0; t.exp_op = 1'b0; t.exp_lat = 0; t.abort_at = 0;
      run_txn(t, $sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
